// File: rtl/nonce_scheduler.sv
// Round-robin nonce chunk dispatch and solution-claim arbitration for NUM_CORES hash cores.
// Define SOL_TIMEOUT_EN to add a HALT response timeout (treated as reject) and the sol_timeout port.
module nonce_scheduler #(
    parameter int unsigned NUM_CORES   = 4,
    parameter int unsigned NONCE_W     = 32,
    parameter int unsigned CHUNK_W     = 20,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [2:0]                     state,
    input  logic [NUM_CORES-1:0]           core_req,
    output logic [NUM_CORES-1:0]           core_grant,
    output logic [NONCE_W-1:0]             chunk_base,
    input  logic [NUM_CORES-1:0]           core_found,
    input  logic [NUM_CORES*NONCE_W-1:0]   core_nonce,
    output logic                           sol_claim,
    output logic [NONCE_W-1:0]             sol_nonce,
    output logic [$clog2(NUM_CORES)-1:0]   sol_core,
    input  logic [1:0]                     sol_response,
    output logic [NUM_CORES-1:0]           core_resume,
    output logic                           core_abort,
`ifdef SOL_TIMEOUT_EN
    output logic                           sol_timeout,
`endif
    output logic                           exhausted
);

    localparam int unsigned IDX_W = $clog2(NUM_CORES);
    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_SOLVE = 3'b011;
    localparam logic [2:0] ST_HALT  = 3'b100;
    localparam logic [NONCE_W:0] CHUNK_INC = (NONCE_W+1)'(1) << CHUNK_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLAIM} fsm_t;

    fsm_t                 fsm_q;
    logic [NONCE_W-1:0]   next_base_q;
    logic [IDX_W-1:0]     gnt_ptr_q;
    logic [IDX_W-1:0]     clm_ptr_q;

    logic [IDX_W-1:0]     gnt_idx_c;
    logic [IDX_W-1:0]     clm_idx_c;
    logic [NONCE_W-1:0]   clm_nonce_c;
    logic [NONCE_W:0]     base_sum_c;
    logic [NUM_CORES-1:0] resume_vec_c;
    logic                 halt_c;
    logic                 accept_c;
    logic                 reject_c;
    logic                 tmo_hit_c;
    logic                 grant_ok_c;

`ifdef SOL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0]     tmo_cnt_q;
`else
    logic                 unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYC == 0);
`endif

    // First set bit of vec at or after ptr, wrapping modulo NUM_CORES.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CORES-1:0] vec,
                                                 input logic [IDX_W-1:0] ptr);
        logic [NUM_CORES-1:0] rot;
        logic [IDX_W:0]       sum;
        logic                 hit;
        rot = NUM_CORES'({vec, vec} >> ptr);
        sum = '0;
        hit = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!hit && rot[k]) begin
                hit = 1'b1;
                sum = {1'b0, ptr} + (IDX_W+1)'(k);
                if (sum >= (IDX_W+1)'(NUM_CORES)) begin
                    sum = sum - (IDX_W+1)'(NUM_CORES);
                end
            end
        end
        return IDX_W'(sum);
    endfunction

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        logic [IDX_W:0] nxt;
        nxt = {1'b0, idx} + (IDX_W+1)'(1);
        if (nxt >= (IDX_W+1)'(NUM_CORES)) begin
            nxt = '0;
        end
        return IDX_W'(nxt);
    endfunction

    // Arbitration picks, chunk adder with carry, and response decode.
    always_comb begin
        gnt_idx_c   = rr_pick(core_req, gnt_ptr_q);
        clm_idx_c   = rr_pick(core_found, clm_ptr_q);
        clm_nonce_c = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (clm_idx_c == IDX_W'(k)) begin
                clm_nonce_c = core_nonce[k*NONCE_W +: NONCE_W];
            end
            resume_vec_c[k] = (sol_core == IDX_W'(k));
        end
        base_sum_c = {1'b0, next_base_q} + CHUNK_INC;
        halt_c     = (fsm_q == S_CLAIM) && (state == ST_HALT);
`ifdef SOL_TIMEOUT_EN
        tmo_hit_c  = halt_c && (sol_response == 2'b00) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
`else
        tmo_hit_c  = 1'b0;
`endif
        accept_c   = halt_c && sol_response[1];
        reject_c   = halt_c && ((sol_response == 2'b01) || tmo_hit_c);
        grant_ok_c = (fsm_q == S_RUN) && !sol_claim && !exhausted && (|core_req);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            next_base_q <= '0;
            gnt_ptr_q   <= '0;
            clm_ptr_q   <= '0;
            core_grant  <= '0;
            chunk_base  <= '0;
            sol_claim   <= 1'b0;
            sol_nonce   <= '0;
            sol_core    <= '0;
            core_resume <= '0;
            core_abort  <= 1'b0;
            exhausted   <= 1'b0;
`ifdef SOL_TIMEOUT_EN
            sol_timeout <= 1'b0;
            tmo_cnt_q   <= '0;
`endif
        end else begin
            core_grant  <= '0;
            core_resume <= '0;
            core_abort  <= 1'b0;
`ifdef SOL_TIMEOUT_EN
            sol_timeout <= 1'b0;
`endif
            // Controller IDLE or an accepted solution: return to S_IDLE with the nonce space rewound.
            if ((state == ST_IDLE) || accept_c) begin
                fsm_q       <= S_IDLE;
                sol_claim   <= 1'b0;
                next_base_q <= '0;
                exhausted   <= 1'b0;
                gnt_ptr_q   <= '0;
                clm_ptr_q   <= '0;
                core_abort  <= accept_c;
`ifdef SOL_TIMEOUT_EN
                tmo_cnt_q   <= '0;
`endif
            end else begin
                unique case (fsm_q)
                    S_IDLE: begin
                        if (state == ST_SOLVE) begin
                            fsm_q <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (grant_ok_c) begin
                            core_grant  <= NUM_CORES'(1) << gnt_idx_c;
                            chunk_base  <= next_base_q;
                            next_base_q <= base_sum_c[NONCE_W-1:0];
                            exhausted   <= base_sum_c[NONCE_W];
                            gnt_ptr_q   <= wrap_inc(gnt_idx_c);
                        end
                        if (|core_found) begin
                            fsm_q     <= S_CLAIM;
                            sol_claim <= 1'b1;
                            sol_nonce <= clm_nonce_c;
                            sol_core  <= clm_idx_c;
                            clm_ptr_q <= wrap_inc(clm_idx_c);
                        end
                    end
                    S_CLAIM: begin
                        if (reject_c) begin
                            fsm_q       <= S_RUN;
                            sol_claim   <= 1'b0;
                            core_resume <= resume_vec_c;
`ifdef SOL_TIMEOUT_EN
                            sol_timeout <= tmo_hit_c;
                            tmo_cnt_q   <= '0;
                        end else if (halt_c && (sol_response == 2'b00)) begin
                            tmo_cnt_q   <= tmo_cnt_q + TMO_W'(1);
`endif
                        end
                    end
                    default: fsm_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Bench for nonce_scheduler: directed literal scenarios plus randomized traffic against a behavioural model.
module tb_nonce_scheduler;

    localparam int NC  = 4;
    localparam int NW  = 32;
    localparam int CW  = 20;
    localparam int TMO = 8;
    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_SOLVE = 3'b011;
    localparam logic [2:0] ST_HALT  = 3'b100;
    localparam longint SPACE = longint'(1) << NW;
    localparam longint CHUNK = longint'(1) << CW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [2:0]        state;
    logic [NC-1:0]     core_req;
    logic [NC-1:0]     core_grant;
    logic [NW-1:0]     chunk_base;
    logic [NC-1:0]     core_found;
    logic [NC*NW-1:0]  core_nonce;
    logic              sol_claim;
    logic [NW-1:0]     sol_nonce;
    logic [1:0]        sol_core;
    logic [1:0]        sol_response;
    logic [NC-1:0]     core_resume;
    logic              core_abort;
    logic              exhausted;
`ifdef SOL_TIMEOUT_EN
    logic              sol_timeout;
    logic              sol_timeout2;
`endif

    logic [2:0]        state2;
    logic [NC-1:0]     req2;
    logic [NC-1:0]     grant2;
    logic [NW-1:0]     base2;
    logic              claim2;
    logic [NW-1:0]     snonce2;
    logic [1:0]        score2;
    logic [NC-1:0]     resume2;
    logic              abort2;
    logic              exh2;

    nonce_scheduler #(.NUM_CORES(NC), .NONCE_W(NW), .CHUNK_W(CW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .state(state), .core_req(core_req), .core_grant(core_grant),
        .chunk_base(chunk_base), .core_found(core_found), .core_nonce(core_nonce),
        .sol_claim(sol_claim), .sol_nonce(sol_nonce), .sol_core(sol_core),
        .sol_response(sol_response), .core_resume(core_resume), .core_abort(core_abort),
`ifdef SOL_TIMEOUT_EN
        .sol_timeout(sol_timeout),
`endif
        .exhausted(exhausted)
    );

    nonce_scheduler #(.NUM_CORES(NC), .NONCE_W(NW), .CHUNK_W(30), .TIMEOUT_CYC(TMO)) dut2 (
        .clk(clk), .rst(rst), .state(state2), .core_req(req2), .core_grant(grant2),
        .chunk_base(base2), .core_found(4'b0000), .core_nonce(128'd0),
        .sol_claim(claim2), .sol_nonce(snonce2), .sol_core(score2),
        .sol_response(2'b00), .core_resume(resume2), .core_abort(abort2),
`ifdef SOL_TIMEOUT_EN
        .sol_timeout(sol_timeout2),
`endif
        .exhausted(exh2)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [NC-1:0] v, input int p);
        for (int k = 0; k < NC; k++) begin
            if (v[(p + k) % NC]) return (p + k) % NC;
        end
        return 0;
    endfunction

    // Behavioural model: mode 0 idle, 1 dispatching, 2 claim outstanding.
    int          m_mode, m_gptr, m_cptr, m_tcnt;
    longint      m_base;
    bit          m_exh;
    logic [NC-1:0] e_grant, e_resume;
    logic [NW-1:0] e_base, e_snonce;
    logic        e_claim, e_abort, e_exh, e_tmo;
    logic [1:0]  e_score;

    always @(posedge clk) begin
        int w;
        bit timed;
        e_grant  = '0;
        e_resume = '0;
        e_abort  = 1'b0;
        e_tmo    = 1'b0;
        timed    = 1'b0;
        if (rst) begin
            m_mode = 0; e_base = '0; e_claim = 1'b0; e_snonce = '0; e_score = '0;
        end else if (state == ST_IDLE) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (state == ST_SOLVE) m_mode = 1;
                1: begin
                    if (!m_exh && core_req != 0) begin
                        w = rr(core_req, m_gptr);
                        e_grant[w] = 1'b1;
                        e_base = NW'(m_base);
                        m_base = m_base + CHUNK;
                        if (m_base >= SPACE) m_exh = 1'b1;
                        m_gptr = (w + 1) % NC;
                    end
                    if (core_found != 0) begin
                        w = rr(core_found, m_cptr);
                        e_claim  = 1'b1;
                        e_snonce = core_nonce[w*NW +: NW];
                        e_score  = 2'(w);
                        m_cptr   = (w + 1) % NC;
                        m_mode   = 2;
                        m_tcnt   = 0;
                    end
                end
                default: if (state == ST_HALT) begin
`ifdef SOL_TIMEOUT_EN
                    if (sol_response == 2'b00) begin
                        m_tcnt++;
                        if (m_tcnt == TMO) timed = 1'b1;
                    end
`endif
                    if (sol_response == 2'b01 || timed) begin
                        e_claim = 1'b0;
                        e_resume[e_score] = 1'b1;
                        e_tmo = timed;
                        m_mode = 1;
                    end else if (sol_response[1]) begin
                        e_claim = 1'b0;
                        e_abort = 1'b1;
                        m_mode = 0;
                    end
                end
            endcase
        end
        if (m_mode == 0) begin
            m_base = 0; m_exh = 1'b0; m_gptr = 0; m_cptr = 0; m_tcnt = 0; e_claim = 1'b0;
        end
        e_exh = m_exh;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_grant", core_grant, e_grant);
            if (e_grant != 0) chk("m_chunk_base", chunk_base, e_base);
            chk("m_sol_claim", sol_claim, e_claim);
            chk("m_sol_nonce", sol_nonce, e_snonce);
            chk("m_sol_core", sol_core, e_score);
            chk("m_resume", core_resume, e_resume);
            chk("m_abort", core_abort, e_abort);
            chk("m_exhausted", exhausted, e_exh);
`ifdef SOL_TIMEOUT_EN
            chk("m_timeout", sol_timeout, e_tmo);
`endif
        end
    end

    logic [NC-1:0] lit_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [NW-1:0] lit_b [5] = '{32'h0, 32'h100000, 32'h200000, 32'h300000, 32'h400000};
    logic [NW-1:0] lit_b2 [4] = '{32'h0, 32'h40000000, 32'h80000000, 32'hC0000000};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        rst = 1'b1; state = ST_IDLE; core_req = '0; core_found = '0; core_nonce = '0;
        sol_response = 2'b00; state2 = ST_IDLE; req2 = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_grant", core_grant, 0);
        chk("rst_claim", sol_claim, 0);
        chk("rst_base", chunk_base, 0);
        chk("rst_exhausted", exhausted, 0);
        chk("rst_abort", core_abort, 0);

        // Round-robin dispatch with all cores requesting.
        rst = 1'b0; state = ST_SOLVE; core_req = 4'hF;
        @(negedge clk);
        chk("A_no_grant_in_idle", core_grant, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("A_grant", core_grant, lit_g[i]);
            chk("A_base", chunk_base, lit_b[i]);
        end

        // Claim, reject, second pending claim, then accept.
        core_req = '0; state = ST_IDLE;
        @(negedge clk);
        state = ST_SOLVE;
        core_nonce[1*NW +: NW] = 32'hAA;
        core_nonce[2*NW +: NW] = 32'hBB;
        core_found = 4'b0110;
        repeat (2) @(negedge clk);
        chk("B_claim", sol_claim, 1);
        chk("B_core", sol_core, 1);
        chk("B_nonce", sol_nonce, 32'hAA);
        state = ST_HALT; sol_response = 2'b01;
        @(negedge clk);
        chk("B_drop", sol_claim, 0);
        chk("B_resume", core_resume, 4'b0010);
        core_found[1] = 1'b0; sol_response = 2'b00;
        @(negedge clk);
        chk("B_claim2", sol_claim, 1);
        chk("B_core2", sol_core, 2);
        chk("B_nonce2", sol_nonce, 32'hBB);
        core_req = 4'b0001; sol_response = 2'b10;
        @(negedge clk);
        chk("B_abort", core_abort, 1);
        chk("B_claim_off", sol_claim, 0);
        chk("B_nonce_hold", sol_nonce, 32'hBB);
        chk("B_no_grant_resp", core_grant, 0);
        core_found = '0; sol_response = 2'b00;
        repeat (3) begin
            @(negedge clk);
            chk("B_blocked", core_grant, 0);
        end
        state = ST_IDLE;
        @(negedge clk);
        state = ST_SOLVE;
        repeat (2) @(negedge clk);
        chk("B_regrant", core_grant, 4'b0001);
        chk("B_regrant_base", chunk_base, 0);

        // Simultaneous grant and claim, then IDLE mid-claim.
        core_nonce[3*NW +: NW] = 32'h1234;
        core_found = 4'b1000;
        @(negedge clk);
        chk("C_sim_grant", core_grant, 4'b0001);
        chk("C_sim_base", chunk_base, 32'h100000);
        chk("C_sim_claim", sol_claim, 1);
        chk("C_sim_core", sol_core, 3);
        state = ST_IDLE;
        @(negedge clk);
        chk("C_idle_claim", sol_claim, 0);
        chk("C_idle_resume", core_resume, 0);
        chk("C_idle_abort", core_abort, 0);
        core_found = '0; state = ST_SOLVE;
        repeat (2) @(negedge clk);
        chk("C_base_rewound", chunk_base, 0);

        // Exhaust the default nonce space.
        state = ST_IDLE; core_req = 4'hF;
        @(negedge clk);
        state = ST_SOLVE;
        repeat (4110) @(negedge clk);
        chk("E_exhausted", exhausted, 1);
        chk("E_no_grant", core_grant, 0);

        // Wide chunks on the second instance: four grants, then exhausted.
        state = ST_IDLE; core_req = '0;
        state2 = ST_SOLVE; req2 = 4'b0001;
        @(negedge clk);
        chk("D_no_grant_in_idle", grant2, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("D_grant", grant2, 4'b0001);
            chk("D_base", base2, lit_b2[i]);
            chk("D_exhausted", exh2, (i == 3) ? 1 : 0);
        end
        repeat (2) begin
            @(negedge clk);
            chk("D_no_fifth", grant2, 0);
            chk("D_exh_hold", exh2, 1);
        end
        state2 = ST_IDLE;
        @(negedge clk);
        chk("D_exh_clear", exh2, 0);

        // Randomized traffic; cores hold core_found until resumed or aborted.
        for (int c = 0; c < 3000; c++) begin
            core_found = core_found & ~e_resume;
            if (e_abort) core_found = '0;
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, 99);
                state = (r < 5) ? ST_IDLE : (r < 65) ? ST_SOLVE : ST_HALT;
            end
            if (state == ST_IDLE) core_found = '0;
            for (int i = 0; i < NC; i++) begin
                if (!core_found[i] && $urandom_range(0, 24) == 0) begin
                    core_nonce[i*NW +: NW] = $urandom;
                    core_found[i] = 1'b1;
                end
            end
            core_req = NC'($urandom);
            sol_response = ($urandom_range(0, 99) < 75) ? 2'b00 : 2'($urandom);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
